// File: rtl/lab3_cache_req_buffer_if.sv
// Handshake bundle between upstream requester, the request buffer and the cache.
// Every *_val/*_rdy pair uses strict valid/ready semantics: a transfer happens in the cycle where both are high.
interface lab3_cache_req_buffer_if;
  logic        memreq_val;
  logic        memreq_rdy;
  logic [76:0] memreq_msg;
  logic        memresp_val;
  logic        memresp_rdy;
  logic [46:0] memresp_msg;
  logic        cache_req_val;
  logic        cache_req_rdy;
  logic [76:0] cache_req_msg;
  logic        cache_resp_val;
  logic        cache_resp_rdy;
  logic [46:0] cache_resp_msg;
  logic        flush;
  logic        flush_done;

  modport master (
    output memreq_val, memreq_msg, memresp_rdy, cache_req_rdy,
           cache_resp_val, cache_resp_msg, flush,
    input  memreq_rdy, memresp_val, memresp_msg, cache_req_val,
           cache_req_msg, cache_resp_rdy, flush_done
  );

  modport slave (
    input  memreq_val, memreq_msg, memresp_rdy, cache_req_rdy,
           cache_resp_val, cache_resp_msg, flush,
    output memreq_rdy, memresp_val, memresp_msg, cache_req_val,
           cache_req_msg, cache_resp_rdy, flush_done
  );
endinterface

// File: rtl/lab3_cache_req_buffer.sv
// Request FIFO, inflight tracker and flush sequencer in front of the cache.
// Macro LAB3_CACHE_RESP_BUF_EN inserts a 1-entry registered buffer on the response path.
module lab3_cache_req_buffer #(
  parameter int p_num_entries  = 2,
  parameter int p_max_inflight = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  lab3_cache_req_buffer_if.slave              bus,
  output logic [1:0]                          dbg_state,
  output logic [$clog2(p_max_inflight+1)-1:0] dbg_inflight
);
  localparam int QW = $clog2(p_num_entries + 1);
  localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int IW = $clog2(p_max_inflight + 1);
  localparam logic [QW-1:0] QDEPTH = QW'(p_num_entries);
  localparam logic [PW-1:0] PLAST  = PW'(p_num_entries - 1);
  localparam logic [IW-1:0] IMAX   = IW'(p_max_inflight);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [76:0]     mem_q [p_num_entries];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [QW-1:0]   count_q, count_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic            memreq_rdy_q, memreq_rdy_d;
  logic            flush_done_q, flush_done_d;
  logic            enq, deq, resp_fire, resp_idle;

`ifdef LAB3_CACHE_RESP_BUF_EN
  logic [46:0] rbuf_q, rbuf_d;
  logic        rbuf_full_q, rbuf_full_d;
  logic        rbuf_load;

  // The entry may be refilled in the same cycle it drains upstream.
  assign bus.cache_resp_rdy = !rbuf_full_q || bus.memresp_rdy;
  assign rbuf_load          = bus.cache_resp_val && bus.cache_resp_rdy;
  assign resp_fire          = rbuf_full_q && bus.memresp_rdy;
  assign resp_idle          = !rbuf_full_q && !resp_fire;
  assign bus.memresp_val    = rbuf_full_q;
  assign bus.memresp_msg    = rbuf_q;

  always_comb begin
    rbuf_d      = rbuf_q;
    rbuf_full_d = rbuf_full_q;
    if (rbuf_load) begin
      rbuf_d      = bus.cache_resp_msg;
      rbuf_full_d = 1'b1;
    end else if (resp_fire) begin
      rbuf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbuf_q      <= '0;
      rbuf_full_q <= 1'b0;
    end else begin
      rbuf_q      <= rbuf_d;
      rbuf_full_q <= rbuf_full_d;
    end
  end
`else
  assign bus.memresp_val    = bus.cache_resp_val;
  assign bus.memresp_msg    = bus.cache_resp_msg;
  assign bus.cache_resp_rdy = bus.memresp_rdy;
  assign resp_fire          = bus.cache_resp_val && bus.memresp_rdy;
  assign resp_idle          = !resp_fire;
`endif

  assign bus.cache_req_val = (count_q != '0) && (inflight_q < IMAX);
  assign bus.cache_req_msg = mem_q[head_q];
  assign bus.memreq_rdy    = memreq_rdy_q;
  assign bus.flush_done    = flush_done_q;
  assign enq               = bus.memreq_val && memreq_rdy_q;
  assign deq               = bus.cache_req_val && bus.cache_req_rdy;
  assign dbg_state         = state_q;
  assign dbg_inflight      = inflight_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    state_d    = state_q;

    if (enq) tail_d = (tail_q == PLAST) ? '0 : tail_q + PW'(1);
    if (deq) head_d = (head_q == PLAST) ? '0 : head_q + PW'(1);

    case ({enq, deq})
      2'b10:   count_d = count_q + QW'(1);
      2'b01:   count_d = count_q - QW'(1);
      default: count_d = count_q;
    endcase

    case ({deq, resp_fire})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      IDLE:    if (bus.flush) state_d = DRAIN;
      DRAIN: begin
        if (!bus.flush) state_d = IDLE;
        else if (count_q == '0 && inflight_q == '0 && resp_idle) state_d = DONE;
      end
      DONE:    if (!bus.flush) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Ready is registered from next-cycle occupancy so it reads 0 while reset is held.
    memreq_rdy_d = (count_d != QDEPTH) && (state_d == IDLE);
    flush_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      memreq_rdy_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      memreq_rdy_q <= memreq_rdy_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= bus.memreq_msg;
  end
endmodule

// File: tb/tb_lab3_cache_req_buffer.sv
// Self-checking bench for lab3_cache_req_buffer: directed scenarios plus a randomized run
// against a queue-based reference model of request order, response order and inflight count.
module tb_lab3_cache_req_buffer;
  localparam int N   = 2;
  localparam int MAX = 4;
  localparam int IW  = $clog2(MAX + 1);
`ifdef LAB3_CACHE_RESP_BUF_EN
  localparam int RESP_LAT = 1;
`else
  localparam int RESP_LAT = 0;
`endif
  localparam logic [2:0] T_READ  = 3'd0;
  localparam logic [2:0] T_WRITE = 3'd1;

  logic          clk;
  logic          reset;
  logic [1:0]    dbg_state;
  logic [IW-1:0] dbg_inflight;
  int            n_cmp;
  int            n_fail;

  lab3_cache_req_buffer_if bus ();

  lab3_cache_req_buffer #(.p_num_entries(N), .p_max_inflight(MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_inflight (dbg_inflight)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.memreq_val     = 1'b0;
    bus.memreq_msg     = '0;
    bus.memresp_rdy    = 1'b0;
    bus.cache_req_rdy  = 1'b0;
    bus.cache_resp_val = 1'b0;
    bus.cache_resp_msg = '0;
    bus.flush          = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // ---------------- message helpers ----------------
  function automatic logic [76:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                         input logic [31:0] a, input logic [31:0] d);
    return {t, op, a, 2'b00, d};
  endfunction

  function automatic logic [46:0] mk_resp(input logic [76:0] r);
    logic [2:0]  t;
    logic [31:0] a;
    t = r[76:74];
    a = r[65:34];
    return {t, r[73:66], 2'b00, 2'b00, (t == T_READ) ? (a ^ 32'hA5A5_5A5A) : 32'h0};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic exp_val;
    idle_inputs();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.memreq_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_memreq_rdy: got %b want 0", bus.memreq_rdy); end
    n_cmp++; if (bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %b want 0", bus.flush_done); end
    n_cmp++; if (bus.cache_req_val !== 1'b0) begin n_fail++; $display("FAIL reset_cache_req_val: got %b want 0", bus.cache_req_val); end
    n_cmp++; if (dbg_inflight !== '0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", dbg_inflight); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    bus.cache_resp_val = 1'b1;
    #1;
    exp_val = (RESP_LAT == 0);
    n_cmp++; if (bus.memresp_val !== exp_val) begin n_fail++; $display("FAIL reset_memresp_val: got %b want %b", bus.memresp_val, exp_val); end
    bus.cache_resp_val = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.memreq_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_before_edge: got %b want 0", bus.memreq_rdy); end
    tick();
    n_cmp++; if (bus.memreq_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_rise: got %b want 1", bus.memreq_rdy); end
  endtask

  task automatic test_single_read();
    logic [76:0] req;
    logic [46:0] got;
    int lat;
    do_reset();
    req = mk_req(T_READ, 8'h05, 32'h1000, 32'h0);
    bus.memreq_val = 1'b1;
    bus.memreq_msg = req;
    #1;
    n_cmp++; if (bus.memreq_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy: got %b want 1", bus.memreq_rdy); end
    n_cmp++; if (bus.cache_req_val !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", bus.cache_req_val); end
    tick();
    bus.memreq_val = 1'b0;
    #1;
    n_cmp++; if (bus.cache_req_val !== 1'b1) begin n_fail++; $display("FAIL single_issue_val: got %b want 1", bus.cache_req_val); end
    n_cmp++; if (bus.cache_req_msg !== req) begin n_fail++; $display("FAIL single_issue_msg: got %h want %h", bus.cache_req_msg, req); end
    bus.cache_req_rdy = 1'b1;
    tick();
    bus.cache_req_rdy = 1'b0;
    #1;
    n_cmp++; if (dbg_inflight !== IW'(1)) begin n_fail++; $display("FAIL single_inflight1: got %0d want 1", dbg_inflight); end
    tick();
    bus.cache_resp_val = 1'b1;
    bus.cache_resp_msg = {T_READ, 8'h05, 2'b00, 2'b00, 32'hdeadbeef};
    bus.memresp_rdy    = 1'b1;
    lat = -1;
    got = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (lat < 0 && bus.memresp_val) begin lat = c; got = bus.memresp_msg; end
      tick();
      bus.cache_resp_val = 1'b0;
    end
    n_cmp++; if (lat !== RESP_LAT) begin n_fail++; $display("FAIL single_resp_latency: got %0d want %0d", lat, RESP_LAT); end
    n_cmp++; if (got[43:36] !== 8'h05) begin n_fail++; $display("FAIL single_resp_opaque: got %h want 05", got[43:36]); end
    n_cmp++; if (got[31:0] !== 32'hdeadbeef) begin n_fail++; $display("FAIL single_resp_data: got %h want deadbeef", got[31:0]); end
    n_cmp++; if (dbg_inflight !== '0) begin n_fail++; $display("FAIL single_inflight0: got %0d want 0", dbg_inflight); end
  endtask

  task automatic test_queue_full();
    logic [76:0] w [3];
    logic        exp_rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int wi, iss;
    do_reset();
    for (int i = 0; i < 3; i++) w[i] = mk_req(T_WRITE, 8'(i + 1), 32'(4 * i), $urandom);
    wi = 0;
    iss = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) bus.cache_req_rdy = 1'b1;
      bus.memreq_val = (wi < 3);
      bus.memreq_msg = w[(wi < 3) ? wi : 2];
      #1;
      if (c < 5) begin
        n_cmp++; if (bus.memreq_rdy !== exp_rdy[c]) begin n_fail++; $display("FAIL full_rdy_c%0d: got %b want %b", c, bus.memreq_rdy, exp_rdy[c]); end
      end
      if (bus.memreq_val && bus.memreq_rdy) wi++;
      if (bus.cache_req_val && bus.cache_req_rdy) begin
        n_cmp++;
        if (iss > 2 || bus.cache_req_msg !== w[(iss > 2) ? 2 : iss]) begin
          n_fail++; $display("FAIL full_issue_order%0d: got addr %h want %h", iss, bus.cache_req_msg[65:34], 32'(4 * iss));
        end
        iss++;
      end
      tick();
    end
    n_cmp++; if (wi !== 3) begin n_fail++; $display("FAIL full_accepted: got %0d want 3", wi); end
    n_cmp++; if (iss !== 3) begin n_fail++; $display("FAIL full_issued: got %0d want 3", iss); end
  endtask

  task automatic test_inflight_limit();
    int sent, iss, last_acc, first;
    do_reset();
    bus.cache_req_rdy = 1'b1;
    bus.memresp_rdy   = 1'b1;
    sent = 0;
    iss = 0;
    last_acc = -1;
    for (int c = 0; c < 16; c++) begin
      bus.memreq_val = (sent < 6);
      bus.memreq_msg = mk_req(T_READ, 8'(sent + 1), 32'(16 * sent), 32'h0);
      #1;
      if (bus.cache_req_val && bus.cache_req_rdy) begin
        n_cmp++; if (bus.cache_req_msg[73:66] !== 8'(iss + 1)) begin n_fail++; $display("FAIL limit_order: got %0d want %0d", bus.cache_req_msg[73:66], iss + 1); end
        iss++;
      end
      if (bus.memreq_val && bus.memreq_rdy) begin sent++; last_acc = c; end
      tick();
    end
    bus.memreq_val = 1'b0;
    n_cmp++; if (iss !== 4) begin n_fail++; $display("FAIL limit_issued: got %0d want 4", iss); end
    n_cmp++; if (sent !== 6) begin n_fail++; $display("FAIL limit_accepted: got %0d want 6", sent); end
    n_cmp++; if (last_acc !== 5) begin n_fail++; $display("FAIL limit_throughput: 6th accept at cycle %0d want 5", last_acc); end
    n_cmp++; if (dbg_inflight !== IW'(4)) begin n_fail++; $display("FAIL limit_inflight: got %0d want 4", dbg_inflight); end
    n_cmp++; if (bus.cache_req_val !== 1'b0) begin n_fail++; $display("FAIL limit_gate: got %b want 0", bus.cache_req_val); end
    bus.cache_resp_val = 1'b1;
    bus.cache_resp_msg = mk_resp(mk_req(T_READ, 8'd1, 32'd0, 32'd0));
    first = -1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (first < 0 && bus.cache_req_val) begin
        first = c;
        n_cmp++; if (bus.cache_req_msg[73:66] !== 8'd5) begin n_fail++; $display("FAIL limit_fifth_msg: got %0d want 5", bus.cache_req_msg[73:66]); end
      end
      tick();
      bus.cache_resp_val = 1'b0;
    end
    n_cmp++; if (first !== 1 + RESP_LAT) begin n_fail++; $display("FAIL limit_fifth_timing: got %0d want %0d", first, 1 + RESP_LAT); end
  endtask

  task automatic test_flush_traffic();
    logic [76:0] pend [$];
    logic [76:0] r1;
    int resp_n, last_fire, rise;
    do_reset();
    bus.cache_req_rdy = 1'b1;
    r1 = mk_req(T_READ, 8'd1, 32'h100, 32'h0);
    bus.memreq_val = 1'b1;
    bus.memreq_msg = r1;
    tick();
    bus.memreq_msg = mk_req(T_READ, 8'd2, 32'h200, 32'h0);
    tick();
    bus.cache_req_rdy = 1'b0;
    bus.memreq_msg = mk_req(T_WRITE, 8'd3, 32'h300, 32'h1234);
    tick();
    pend.push_back(r1);
    bus.memreq_msg = mk_req(T_WRITE, 8'd9, 32'h900, 32'h0);
    n_cmp++; if (dbg_inflight !== IW'(1)) begin n_fail++; $display("FAIL flush_setup_inflight: got %0d want 1", dbg_inflight); end
    bus.flush = 1'b1;
    resp_n = 0;
    last_fire = -10;
    rise = -1;
    for (int c = 0; c < 80 && rise < 0; c++) begin
      bus.cache_req_rdy  = 1'($urandom_range(0, 1));
      bus.memresp_rdy    = 1'($urandom_range(0, 1));
      bus.cache_resp_val = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      if (pend.size() > 0) bus.cache_resp_msg = mk_resp(pend[0]);
      #1;
      n_cmp++; if (bus.memreq_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_rdy_c%0d: got %b want 0", c, bus.memreq_rdy); end
      if (bus.flush_done) begin
        rise = c;
        n_cmp++; if (resp_n !== 3) begin n_fail++; $display("FAIL flush_done_early: responses %0d want 3", resp_n); end
        n_cmp++; if (c !== last_fire + 2) begin n_fail++; $display("FAIL flush_done_timing: rose at %0d want %0d", c, last_fire + 2); end
      end
      if (bus.cache_req_val && bus.cache_req_rdy) pend.push_back(bus.cache_req_msg);
      if (bus.cache_resp_val && bus.cache_resp_rdy) void'(pend.pop_front());
      if (bus.memresp_val && bus.memresp_rdy) begin
        resp_n++;
        n_cmp++; if (bus.memresp_msg[43:36] !== 8'(resp_n)) begin n_fail++; $display("FAIL flush_resp_order: got %0d want %0d", bus.memresp_msg[43:36], resp_n); end
        last_fire = c;
      end
      tick();
    end
    n_cmp++; if (rise < 0) begin n_fail++; $display("FAIL flush_timeout: flush_done got 0 want 1 within 80 cycles"); end
    idle_inputs();
    bus.flush = 1'b0;
    #1;
    n_cmp++; if (bus.flush_done !== 1'b1) begin n_fail++; $display("FAIL flush_done_hold: got %b want 1", bus.flush_done); end
    tick();
    n_cmp++; if (bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL flush_done_fall: got %b want 0", bus.flush_done); end
    n_cmp++; if (bus.memreq_rdy !== 1'b1) begin n_fail++; $display("FAIL flush_exit_rdy: got %b want 1", bus.memreq_rdy); end
  endtask

  task automatic test_flush_timing();
    do_reset();
    bus.flush = 1'b1;
    #1;
    n_cmp++; if (bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL ftime_n: got %b want 0", bus.flush_done); end
    tick();
    n_cmp++; if (bus.flush_done !== 1'b0 || dbg_state !== 2'd1) begin n_fail++; $display("FAIL ftime_n1: done %b state %0d want 0/1", bus.flush_done, dbg_state); end
    tick();
    n_cmp++; if (bus.flush_done !== 1'b1) begin n_fail++; $display("FAIL ftime_n2: got %b want 1", bus.flush_done); end
    bus.flush = 1'b0;
    tick();
    n_cmp++; if (bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL ftime_fall: got %b want 0", bus.flush_done); end
  endtask

  task automatic test_flush_abort_reset();
    logic [76:0] a, b;
    do_reset();
    a = mk_req(T_WRITE, 8'h11, 32'h40, $urandom);
    b = mk_req(T_READ, 8'h22, 32'h80, 32'h0);
    bus.memreq_val = 1'b1;
    bus.memreq_msg = a;
    tick();
    bus.memreq_msg = b;
    tick();
    bus.memreq_val = 1'b0;
    bus.flush = 1'b1;
    tick();
    n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL abort_drain: state %0d want 1", dbg_state); end
    tick();
    n_cmp++; if (dbg_state !== 2'd1 || bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL abort_hold: state %0d done %b want 1/0", dbg_state, bus.flush_done); end
    bus.flush = 1'b0;
    tick();
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL abort_idle: state %0d want 0", dbg_state); end
    n_cmp++; if (bus.cache_req_val !== 1'b1 || bus.cache_req_msg !== a) begin n_fail++; $display("FAIL abort_head: val %b msg %h want 1/%h", bus.cache_req_val, bus.cache_req_msg, a); end
    bus.cache_req_rdy = 1'b1;
    tick();
    bus.cache_req_rdy = 1'b0;
    n_cmp++; if (bus.cache_req_msg !== b) begin n_fail++; $display("FAIL abort_second: got %h want %h", bus.cache_req_msg, b); end
    bus.flush = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.memreq_rdy !== 1'b0 || bus.flush_done !== 1'b0) begin n_fail++; $display("FAIL midreset_outs: rdy %b done %b want 0/0", bus.memreq_rdy, bus.flush_done); end
    n_cmp++; if (bus.cache_req_val !== 1'b0) begin n_fail++; $display("FAIL midreset_req_val: got %b want 0", bus.cache_req_val); end
    n_cmp++; if (dbg_inflight !== '0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL midreset_state: inflight %0d state %0d want 0/0", dbg_inflight, dbg_state); end
    bus.flush = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.memreq_rdy !== 1'b1 || bus.cache_req_val !== 1'b0) begin n_fail++; $display("FAIL midreset_after: rdy %b val %b want 1/0", bus.memreq_rdy, bus.cache_req_val); end
  endtask

  task automatic test_resp_stall();
    logic [46:0] exp;
    logic        fired;
    do_reset();
    bus.cache_req_rdy = 1'b1;
    bus.memreq_val = 1'b1;
    bus.memreq_msg = mk_req(T_READ, 8'h07, 32'h2000, 32'h0);
    tick();
    bus.memreq_val = 1'b0;
    tick();
    bus.cache_req_rdy = 1'b0;
    exp = {T_READ, 8'h07, 2'b00, 2'b00, $urandom};
    bus.cache_resp_val = 1'b1;
    bus.cache_resp_msg = exp;
    bus.memresp_rdy    = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c >= RESP_LAT) begin
        n_cmp++; if (bus.memresp_val !== 1'b1 || bus.memresp_msg !== exp) begin n_fail++; $display("FAIL stall_hold_c%0d: val %b msg %h want 1/%h", c, bus.memresp_val, bus.memresp_msg, exp); end
        n_cmp++; if (dbg_inflight !== IW'(1)) begin n_fail++; $display("FAIL stall_inflight_c%0d: got %0d want 1", c, dbg_inflight); end
      end
      fired = bus.cache_resp_val && bus.cache_resp_rdy;
      tick();
      if (fired) bus.cache_resp_val = 1'b0;
    end
    bus.memresp_rdy = 1'b1;
    #1;
    n_cmp++; if (bus.memresp_val !== 1'b1) begin n_fail++; $display("FAIL stall_release_val: got %b want 1", bus.memresp_val); end
    fired = bus.cache_resp_val && bus.cache_resp_rdy;
    tick();
    if (fired) bus.cache_resp_val = 1'b0;
    #1;
    n_cmp++; if (dbg_inflight !== '0) begin n_fail++; $display("FAIL stall_release_inflight: got %0d want 0", dbg_inflight); end
    n_cmp++; if (bus.memresp_val !== 1'b0) begin n_fail++; $display("FAIL stall_release_empty: got %b want 0", bus.memresp_val); end
  endtask

  task automatic test_random();
    logic [76:0] exp_q [$];
    logic [46:0] resp_q [$];
    logic [76:0] pend [$];
    logic [46:0] want;
    logic        exp_rdy, exp_val;
    int m_inflight, seq;
    do_reset();
    m_inflight = 0;
    seq = 0;
    for (int c = 0; c < 600; c++) begin
      if (c < 500) begin
        bus.memreq_val    = ($urandom_range(0, 2) != 0);
        bus.memreq_msg    = mk_req(3'($urandom_range(0, 1)), 8'(seq), {$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom);
        bus.cache_req_rdy = ($urandom_range(0, 3) != 0);
        bus.memresp_rdy   = ($urandom_range(0, 3) != 0);
        bus.cache_resp_val = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      end else begin
        bus.memreq_val     = 1'b0;
        bus.cache_req_rdy  = 1'b1;
        bus.memresp_rdy    = 1'b1;
        bus.cache_resp_val = (pend.size() > 0);
      end
      if (pend.size() > 0) bus.cache_resp_msg = mk_resp(pend[0]);
      #1;
      exp_rdy = (exp_q.size() < N);
      exp_val = (exp_q.size() > 0) && (m_inflight < MAX);
      n_cmp++; if (bus.memreq_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand_rdy_c%0d: got %b want %b", c, bus.memreq_rdy, exp_rdy); end
      n_cmp++; if (bus.cache_req_val !== exp_val) begin n_fail++; $display("FAIL rand_req_val_c%0d: got %b want %b", c, bus.cache_req_val, exp_val); end
      n_cmp++; if (dbg_inflight !== IW'(m_inflight)) begin n_fail++; $display("FAIL rand_inflight_c%0d: got %0d want %0d", c, dbg_inflight, m_inflight); end
      if (bus.cache_req_val && exp_q.size() > 0) begin
        n_cmp++; if (bus.cache_req_msg !== exp_q[0]) begin n_fail++; $display("FAIL rand_req_msg_c%0d: got %h want %h", c, bus.cache_req_msg, exp_q[0]); end
      end
      if (bus.memresp_val && bus.memresp_rdy) begin
        want = (resp_q.size() > 0) ? resp_q.pop_front() : 'x;
        n_cmp++; if (bus.memresp_msg !== want) begin n_fail++; $display("FAIL rand_resp_c%0d: got %h want %h", c, bus.memresp_msg, want); end
        m_inflight--;
      end
      if (bus.cache_resp_val && bus.cache_resp_rdy) void'(pend.pop_front());
      if (bus.cache_req_val && bus.cache_req_rdy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pend.push_back(bus.cache_req_msg);
        m_inflight++;
      end
      if (bus.memreq_val && bus.memreq_rdy) begin
        exp_q.push_back(bus.memreq_msg);
        resp_q.push_back(mk_resp(bus.memreq_msg));
        seq++;
      end
      tick();
    end
    n_cmp++; if (resp_q.size() != 0 || exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: left %0d resp %0d req want 0/0", resp_q.size(), exp_q.size()); end
    n_cmp++; if (dbg_inflight !== '0) begin n_fail++; $display("FAIL rand_final_inflight: got %0d want 0", dbg_inflight); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_queue_full();
    test_inflight_limit();
    test_flush_timing();
    test_flush_traffic();
    test_flush_abort_reset();
    test_resp_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
